prog_clock_divider: RTL and testbench

- Programmable integer-N feedback divider clocked by the VCO output.
- Produces the divided clock that the phase-frequency detector compares against the reference, closing the PLL loop.
- Divide ratio is reloadable at run time through a pulse handshake.
- A new ratio takes effect only at a period boundary, so the PFD never sees a truncated or glitched feedback period.

---
 rtl/prog_clock_divider_if.sv | 37 +++
 rtl/prog_clock_divider.sv | 188 ++++++++++++++++++
 tb/tb_prog_clock_divider.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/prog_clock_divider_if.sv
// ---------------------------------------------------------------------------
// prog_clock_divider_if
// Control/status bundle of the programmable PLL feedback divider.
//
//   enable     run control (low holds the divider idle)
//   div_ratio  requested divide ratio N, sampled when div_load=1
//   div_load   one-cycle request to load div_ratio
//   div_ack    one-cycle pulse when a loaded ratio becomes active
//   cur_ratio  currently active divide ratio
//   div_out    divided clock towards the PFD
//   tc_pulse   terminal-count pulse, last cycle of each period
//   ratio_err  sticky flag, an illegal ratio load was rejected
//
// master: the controller driving the divider; slave: the divider itself.
// ---------------------------------------------------------------------------
interface prog_clock_divider_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic [WIDTH-1:0] div_ratio;
    logic             div_load;
    logic             div_ack;
    logic [WIDTH-1:0] cur_ratio;
    logic             div_out;
    logic             tc_pulse;
    logic             ratio_err;

    modport master (
        output enable, div_ratio, div_load,
        input  div_ack, cur_ratio, div_out, tc_pulse, ratio_err
    );

    modport slave (
        input  enable, div_ratio, div_load,
        output div_ack, cur_ratio, div_out, tc_pulse, ratio_err
    );
endinterface

// File: rtl/prog_clock_divider.sv
// ---------------------------------------------------------------------------
// prog_clock_divider
// Integer-N feedback divider clocked by the VCO. Produces the divided clock
// the PFD compares against the reference. The divide ratio can be reloaded
// at run time; a new ratio only takes effect at a period boundary so the
// PFD never sees a truncated period.
//
// Ports:
//   clock  VCO clock, all state changes on its rising edge
//   reset  synchronous active-high reset, dominates all other inputs
//   bus    prog_clock_divider_if.slave (run control, ratio load handshake,
//          divided clock and status); every output is registered
// ---------------------------------------------------------------------------
module prog_clock_divider #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    prog_clock_divider_if.slave   bus
);

    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TWO      = ONE << 1;
    localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH:0]   ONE_WIDE = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cur_ratio_r;
    logic [WIDTH-1:0] pend_r;
    logic             pend_valid_r;
    logic             div_out_r;
    logic             tc_pulse_r;
    logic             div_ack_r;
    logic             ratio_err_r;

    logic             load_ok_s;
    logic             load_bad_s;
    logic             wrap_s;
    logic             apply_s;
    logic [WIDTH-1:0] eff_ratio_s;
    logic [WIDTH-1:0] eff_last_s;
    logic [WIDTH-1:0] next_cnt_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] half_s;

    // Next-period decode: load classification, wrap, ratio hand-over, next count and high-phase length.
    always_comb begin
        load_ok_s   = 1'b0;
        load_bad_s  = 1'b0;
        wrap_s      = 1'b0;
        apply_s     = 1'b0;
        eff_ratio_s = cur_ratio_r;
        eff_last_s  = ZERO;
        next_cnt_s  = ZERO;
        sum_s       = {(WIDTH+1){1'b0}};
        half_s      = ZERO;

        if (bus.div_load) begin
            if (bus.div_ratio >= TWO) begin
                load_ok_s = 1'b1;
            end else begin
                load_bad_s = 1'b1;
            end
        end else begin
            load_ok_s  = 1'b0;
            load_bad_s = 1'b0;
        end

        // cur_ratio is always >= 2, so the subtraction cannot underflow
        wrap_s = (cnt_r == (cur_ratio_r - ONE));

        // Pending ratio only moves in at a period boundary: immediately
        // while idle, or on the wrap edge of a running period.
        case (state_r)
            IDLE:    apply_s = pend_valid_r;
            RUN:     apply_s = pend_valid_r & bus.enable & wrap_s;
            default: apply_s = 1'b0;
        endcase

        if (apply_s) begin
            eff_ratio_s = pend_r;
        end else begin
            eff_ratio_s = cur_ratio_r;
        end
        eff_last_s = eff_ratio_s - ONE;

        if ((state_r == RUN) && !wrap_s) begin
            next_cnt_s = cnt_r + ONE;
        end else begin
            next_cnt_s = ZERO;
        end

        // ceil(N/2) computed one bit wider so N = 2^WIDTH-1 cannot overflow
        sum_s  = {1'b0, eff_ratio_s} + ONE_WIDE;
        half_s = sum_s[WIDTH:1];
    end

    // Divider FSM with pending-ratio register and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= ZERO;
            cur_ratio_r  <= DEF_DIV;
            pend_r       <= ZERO;
            pend_valid_r <= 1'b0;
            div_out_r    <= 1'b0;
            tc_pulse_r   <= 1'b0;
            div_ack_r    <= 1'b0;
            ratio_err_r  <= 1'b0;
        end else begin
            // A fresh legal load always wins, even on the edge that
            // consumes the previous pending value; it then waits for the
            // next boundary.
            if (load_ok_s) begin
                pend_r       <= bus.div_ratio;
                pend_valid_r <= 1'b1;
            end else if (apply_s) begin
                pend_valid_r <= 1'b0;
            end else begin
                pend_valid_r <= pend_valid_r;
            end

            if (load_bad_s) begin
                ratio_err_r <= 1'b1;
            end else begin
                ratio_err_r <= ratio_err_r;
            end

            if (apply_s) begin
                cur_ratio_r <= pend_r;
            end else begin
                cur_ratio_r <= cur_ratio_r;
            end
            div_ack_r <= apply_s;

            case (state_r)
                IDLE: begin
                    if (bus.enable) begin
                        state_r    <= RUN;
                        cnt_r      <= ZERO;
                        div_out_r  <= 1'b1;
                        tc_pulse_r <= 1'b0;
                    end else begin
                        state_r    <= IDLE;
                        cnt_r      <= ZERO;
                        div_out_r  <= 1'b0;
                        tc_pulse_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (!bus.enable) begin
                        // abort the period at once
                        state_r    <= IDLE;
                        cnt_r      <= ZERO;
                        div_out_r  <= 1'b0;
                        tc_pulse_r <= 1'b0;
                    end else begin
                        state_r    <= RUN;
                        cnt_r      <= next_cnt_s;
                        div_out_r  <= (next_cnt_s < half_s);
                        tc_pulse_r <= (next_cnt_s == eff_last_s);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    cnt_r      <= ZERO;
                    div_out_r  <= 1'b0;
                    tc_pulse_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.div_ack   = div_ack_r;
    assign bus.cur_ratio = cur_ratio_r;
    assign bus.div_out   = div_out_r;
    assign bus.tc_pulse  = tc_pulse_r;
    assign bus.ratio_err = ratio_err_r;

endmodule

// File: tb/tb_prog_clock_divider.sv
// ---------------------------------------------------------------------------
// tb_prog_clock_divider
// Directed scenarios followed by randomized stimulus, checked every cycle
// against a behavioural model that tracks "position within the period",
// the active ratio and the latest pending request.
// ---------------------------------------------------------------------------
module tb_prog_clock_divider;

    logic clock;
    logic reset;

    prog_clock_divider_if #(.WIDTH(8)) bus ();

    prog_clock_divider #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // VCO clock stand-in.
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state.
    int m_run;
    int m_pos;
    int m_n;
    int m_err;
    int m_ack;
    int m_pend[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit en, input bit ld, input int r, input bit rs);
        int  newn;
        bit  wrap;
        bit  apply;
        if (rs) begin
            m_run = 0; m_pos = 0; m_n = 4; m_err = 0; m_ack = 0;
            m_pend.delete();
        end else begin
            wrap  = (m_run != 0) && (m_pos == m_n - 1);
            apply = (m_pend.size() > 0) && ((m_run == 0) || (en && wrap));
            newn  = apply ? m_pend[0] : m_n;
            m_ack = apply ? 1 : 0;
            if (apply) m_pend.delete();
            if (ld) begin
                if (r >= 2) begin
                    m_pend.delete();
                    m_pend.push_back(r);
                end else begin
                    m_err = 1;
                end
            end
            if (m_run == 0) begin
                m_run = en ? 1 : 0;
                m_pos = 0;
            end else if (!en) begin
                m_run = 0;
                m_pos = 0;
            end else begin
                m_pos = wrap ? 0 : m_pos + 1;
            end
            m_n = newn;
        end
    endtask

    // One clock: drive inputs, advance the model, compare all outputs.
    task automatic cyc(input bit en, input bit ld, input int r, input bit rs);
        bit exp_out;
        bit exp_tc;
        bus.enable    = en;
        bus.div_load  = ld;
        bus.div_ratio = 8'(r);
        reset         = rs;
        @(posedge clock);
        model_step(en, ld, r, rs);
        #1;
        exp_out = (m_run != 0) && (m_pos < (m_n + 1) / 2);
        exp_tc  = (m_run != 0) && (m_pos == m_n - 1);
        check_eq("div_out",   32'(bus.div_out),   32'(exp_out));
        check_eq("tc_pulse",  32'(bus.tc_pulse),  32'(exp_tc));
        check_eq("div_ack",   32'(bus.div_ack),   32'(m_ack));
        check_eq("cur_ratio", 32'(bus.cur_ratio), 32'(m_n));
        check_eq("ratio_err", 32'(bus.ratio_err), 32'(m_err));
    endtask

    task automatic run(input int n, output int acks);
        acks = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 0, 1'b0);
            acks += int'(bus.div_ack);
        end
    endtask

    task automatic run_until_tc();
        int k = 0;
        while (bus.tc_pulse !== 1'b1 && k < 600) begin
            cyc(1'b1, 1'b0, 0, 1'b0);
            k++;
        end
        check_eq("wait_tc", 32'(bus.tc_pulse), 32'd1);
    endtask

    task automatic run_until_ack();
        int k = 0;
        while (bus.div_ack !== 1'b1 && k < 600) begin
            cyc(1'b1, 1'b0, 0, 1'b0);
            k++;
        end
        check_eq("wait_ack", 32'(bus.div_ack), 32'd1);
    endtask

    initial begin
        logic [7:0] pat;
        int         acks;
        int         r;

        clock         = 1'b0;
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.div_load  = 1'b0;
        bus.div_ratio = 8'd0;
        m_run = 0; m_pos = 0; m_n = 4; m_err = 0; m_ack = 0;

        // Reset state and default ratio 4: pattern 1,1,0,0.
        cyc(1'b0, 1'b0, 0, 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b1);
        check_eq("rst_cur_ratio", 32'(bus.cur_ratio), 32'd4);
        check_eq("rst_div_out",   32'(bus.div_out),   32'd0);
        pat = 8'd0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 0, 1'b0);
            pat = {pat[6:0], bus.div_out};
        end
        check_eq("pattern_n4", 32'(pat), 32'h0000_00CC);

        // Load 5 at cnt=1: current period completes, then 5-cycle periods.
        cyc(1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b1, 5, 1'b0);
        run(12, acks);
        check_eq("n5_acks", 32'(acks), 32'd1);
        check_eq("n5_cur",  32'(bus.cur_ratio), 32'd5);

        // Load 6 then 7 before the wrap: only 7 applies, single ack.
        run_until_tc();
        cyc(1'b1, 1'b1, 6, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b1, 7, 1'b0);
        run(16, acks);
        check_eq("n7_acks", 32'(acks), 32'd1);
        check_eq("n7_cur",  32'(bus.cur_ratio), 32'd7);

        // Illegal load of 1 is rejected and flagged; a load of 3 still works.
        cyc(1'b1, 1'b1, 1, 1'b0);
        check_eq("err_set", 32'(bus.ratio_err), 32'd1);
        run(14, acks);
        check_eq("err_no_ack", 32'(acks), 32'd0);
        check_eq("err_cur",    32'(bus.cur_ratio), 32'd7);
        cyc(1'b1, 1'b1, 3, 1'b0);
        run(20, acks);
        check_eq("n3_acks", 32'(acks), 32'd1);
        check_eq("n3_cur",  32'(bus.cur_ratio), 32'd3);
        check_eq("err_sticky", 32'(bus.ratio_err), 32'd1);

        // Reset at cnt=2 with N=8 and pending 10: pending is discarded.
        cyc(1'b1, 1'b1, 8, 1'b0);
        run_until_ack();
        cyc(1'b1, 1'b1, 10, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b1);
        check_eq("rst2_div_out", 32'(bus.div_out),   32'd0);
        check_eq("rst2_tc",      32'(bus.tc_pulse),  32'd0);
        check_eq("rst2_ack",     32'(bus.div_ack),   32'd0);
        check_eq("rst2_err",     32'(bus.ratio_err), 32'd0);
        check_eq("rst2_cur",     32'(bus.cur_ratio), 32'd4);
        run(25, acks);
        check_eq("rst2_no_ack", 32'(acks), 32'd0);
        check_eq("rst2_cur_after", 32'(bus.cur_ratio), 32'd4);

        // N=3: drop enable at cnt=1, restart 3 cycles later.
        cyc(1'b1, 1'b1, 3, 1'b0);
        run_until_ack();
        cyc(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 0, 1'b0);
            check_eq("idle_div_out", 32'(bus.div_out),  32'd0);
            check_eq("idle_tc",      32'(bus.tc_pulse), 32'd0);
        end
        pat = 8'd0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 0, 1'b0);
            pat = {pat[6:0], bus.div_out};
        end
        check_eq("restart_pattern", 32'(pat), 32'h0000_000D);

        // Randomized phase against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(9, 0) == 0) begin
                r = int'($urandom_range(255, 250));
            end else begin
                r = int'($urandom_range(9, 0));
            end
            cyc(($urandom_range(15, 0) != 0),
                ($urandom_range(5, 0) == 0),
                r,
                ($urandom_range(299, 0) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
